// File: rtl/game_pkg.sv
// Shared encodings for the invader game-control slice: FSM states,
// LFSR feedback taps and level width.
package game_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_WIN   = 2'd2,
        ST_LOSE  = 2'd3
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int NIVEL_W = 4;
    localparam logic [NIVEL_W-1:0] NIVEL_MAX = '1;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, loads seed on reset and steps every clock.
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= seed;
        else       q <= {q[14:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/game_engine_multi.sv
// Invader game control: win/lose/level FSM, weighted score and a sequential
// column-scan fire engine over N_TIROS channels. GAME_ENGINE_PAUSE_EN adds btn_P/PAUSE.
module game_engine_multi
    import game_pkg::*;
#(
    parameter int          LINHAS  = 5,
    parameter int          COLUNAS = 11,
    parameter int          N_TIROS = 2,
    parameter int          ATRASO  = 100000,
    parameter int          SCORE_W = 12,
    parameter logic [15:0] SEED    = 16'hACE1,
    localparam int         CW      = $clog2(COLUNAS),
    localparam int         LW      = $clog2(LINHAS),
    localparam int         NV      = LINHAS * COLUNAS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NV-1:0]           enemy_vivos,
    input  logic                    jogador_vivo,
    input  logic                    vitoria_enemy,
    input  logic                    btn_D,
`ifdef GAME_ENGINE_PAUSE_EN
    input  logic                    btn_P,
`endif
    output logic                    restart,
    output logic [SCORE_W-1:0]      score,
    output logic [NIVEL_W-1:0]      nivel,
    output logic [N_TIROS-1:0]      tiro_valid,
    output logic [N_TIROS*CW-1:0]   tiro_col,
    output logic [N_TIROS*LW-1:0]   tiro_lin,
    output logic [1:0]              estado_jogo
);

    localparam int IW  = $clog2(NV);
    localparam int TW  = $clog2(ATRASO);
    localparam int CHW = (N_TIROS > 1) ? $clog2(N_TIROS) : 1;
    localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 1);

    state_t state, state_n;
    logic   restart_n, restart_d, ignore;
    logic   clr_score, clr_nivel, inc_nivel;
    logic   freeze;

    // Buttons are active-low: a press is a 1->0 edge after two sync flops.
    logic [2:0] d_sync;
    logic       press_d, press_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) d_sync <= '1;
        else       d_sync <= {d_sync[1:0], btn_D};
    end
    assign press_d = d_sync[2] & ~d_sync[1];

`ifdef GAME_ENGINE_PAUSE_EN
    logic [2:0] p_sync;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) p_sync <= '1;
        else       p_sync <= {p_sync[1:0], btn_P};
    end
    assign press_p = p_sync[2] & ~p_sync[1];
`else
    assign press_p = 1'b0;
`endif

    // The field reloads over the restart cycle and the one after it.
    assign ignore = restart | restart_d;

    always_comb begin
        state_n   = state;
        restart_n = 1'b0;
        clr_score = 1'b0;
        clr_nivel = 1'b0;
        inc_nivel = 1'b0;
        case (state)
            ST_RUN: begin
                if (vitoria_enemy || !jogador_vivo) begin
                    state_n = ST_LOSE;
                end else if (!ignore && enemy_vivos == '0) begin
                    state_n = ST_WIN;
                end else if (press_d) begin
                    restart_n = 1'b1;
                    clr_score = 1'b1;
                    clr_nivel = 1'b1;
                end else if (press_p) begin
                    state_n = ST_PAUSE;
                end
            end
            ST_WIN: begin
                if (press_d) begin
                    state_n   = ST_RUN;
                    restart_n = 1'b1;
                    inc_nivel = 1'b1;
                end
            end
            ST_LOSE, ST_PAUSE: begin
                if (press_d) begin
                    state_n   = ST_RUN;
                    restart_n = 1'b1;
                    clr_score = 1'b1;
                    clr_nivel = 1'b1;
                end else if (state == ST_PAUSE && press_p) begin
                    state_n = ST_RUN;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    assign freeze = (state == ST_PAUSE) && (state_n == ST_PAUSE);

    // Scoring: each vanished bit at row r is worth LINHAS - r.
    logic [NV-1:0] prev_vivos, kill;
    logic [31:0]   pts, score_sum;
    logic [SCORE_W-1:0] score_sat;

    always_comb begin
        kill = prev_vivos & ~enemy_vivos;
        pts  = '0;
        for (int r = 0; r < LINHAS; r++)
            for (int c = 0; c < COLUNAS; c++)
                if (kill[IW'(r*COLUNAS + c)]) pts = pts + 32'(LINHAS - r);
        score_sum = 32'(score) + pts;
        score_sat = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            restart    <= 1'b0;
            restart_d  <= 1'b0;
            prev_vivos <= '0;
            score      <= '0;
            nivel      <= '0;
        end else begin
            state     <= state_n;
            restart   <= restart_n;
            restart_d <= restart;
            // Leaving PAUSE rebases prev_vivos so paused kills never score.
            if (!freeze) prev_vivos <= enemy_vivos;
            if (clr_score)                        score <= '0;
            else if (state == ST_RUN && !ignore)  score <= score_sat;
            if (clr_nivel)      nivel <= '0;
            else if (inc_nivel) nivel <= (nivel == NIVEL_MAX) ? nivel : nivel + 1'b1;
        end
    end

    assign estado_jogo = state;

    // Fire engine
    logic [15:0] lfsr_q;
    logic        lfsr_unused;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .q     (lfsr_q)
    );
    assign lfsr_unused = ^lfsr_q[15:8];

    logic [TW-1:0]  timer;
    logic           scan_act, col_hit, fire_run, fire_hold;
    logic [CW-1:0]  scan_col, scan_cnt, start_col;
    logic [CHW-1:0] scan_ch, ch_ptr;
    logic [LW-1:0]  hit_lin;
    logic [N_TIROS-1:0][CW-1:0] tcol;
    logic [N_TIROS-1:0][LW-1:0] tlin;

    assign start_col = CW'(32'(lfsr_q[7:0]) % COLUNAS);
    assign fire_run  = (state == ST_RUN) && (state_n == ST_RUN);
    assign fire_hold = (state == ST_PAUSE) || (state_n == ST_PAUSE);

    // Last live row wins the loop, so hit_lin is the bottom-most enemy.
    always_comb begin
        col_hit = 1'b0;
        hit_lin = '0;
        for (int r = 0; r < LINHAS; r++)
            if (enemy_vivos[IW'(r*COLUNAS) + IW'(scan_col)]) begin
                col_hit = 1'b1;
                hit_lin = LW'(r);
            end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer      <= '0;
            scan_act   <= 1'b0;
            scan_col   <= '0;
            scan_cnt   <= '0;
            scan_ch    <= '0;
            ch_ptr     <= '0;
            tiro_valid <= '0;
            tcol       <= '0;
            tlin       <= '0;
        end else begin
            tiro_valid <= '0;
            if (fire_run) begin
                if (scan_act) begin
                    if (col_hit) begin
                        tiro_valid[scan_ch] <= 1'b1;
                        tcol[scan_ch]       <= scan_col;
                        tlin[scan_ch]       <= hit_lin;
                        scan_act            <= 1'b0;
                    end else if (scan_cnt == CW'(COLUNAS-1)) begin
                        scan_act <= 1'b0;
                    end else begin
                        scan_col <= (scan_col == CW'(COLUNAS-1)) ? '0 : scan_col + 1'b1;
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                if (timer == TW'(ATRASO-1)) begin
                    timer    <= '0;
                    scan_act <= 1'b1;
                    scan_col <= start_col;
                    scan_cnt <= '0;
                    scan_ch  <= ch_ptr;
                    ch_ptr   <= (ch_ptr == CHW'(N_TIROS-1)) ? '0 : ch_ptr + 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end else if (!fire_hold) begin
                timer    <= '0;
                scan_act <= 1'b0;
            end
        end
    end

    assign tiro_col = tcol;
    assign tiro_lin = tlin;

endmodule

// File: doc/game_engine_multi.md
Name: game_engine_multi

Overview:
- Next-generation game-control block for the invader playfield: tracks win/lose/level state, keeps a weighted running score and issues enemy fire commands on up to N_TIROS independent channels.
- Sits between the enemy-grid/collision logic (which supplies the alive bitmap and the player status) and the projectile generators and score display.
- Replaces combinational shooter picking with a sequential column scan that always selects the bottom-most live enemy of a column.

Parameters:
LINHAS, 5, enemy rows; row 0 is the top row.
COLUNAS, 11, enemy columns; bitmap index = lin*COLUNAS + col.
N_TIROS, 2, number of fire channels, range 1..4.
ATRASO, 100000, clk cycles between fire ticks, must be >= COLUNAS+2.
SCORE_W, 12, score width in bits.
SEED, 16'hACE1, LFSR reset value, must be nonzero.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
enemy_vivos  in  LINHAS*COLUNAS  alive bitmap, 1 = alive.
jogador_vivo  in  1  player alive.
vitoria_enemy  in  1  enemies reached the base.
btn_D  in  1  restart/continue button, active-low, asynchronous to clk.
restart  out  1  one-cycle field-reload pulse.
score  out  SCORE_W  accumulated score.
nivel  out  4  current level, starting at 0.
tiro_valid  out  N_TIROS  one-cycle fire pulse per channel.
tiro_col  out  N_TIROS*CW  packed shooter columns, CW = $clog2(COLUNAS).
tiro_lin  out  N_TIROS*LW  packed shooter rows, LW = $clog2(LINHAS).
estado_jogo  out  2  0 = paused, 1 = running, 2 = player won, 3 = player lost.

Behaviour:
- Reset (asynchronous): state RUN, score 0, nivel 0, all tiro_* outputs 0, restart 0, LFSR = SEED, timer 0, channel pointer 0.
- btn_D handling: a 2-flop synchronizer, then falling-edge detect, produces `press`. press is asserted for exactly one cycle per physical press.
- FSM states: RUN, WIN, LOSE (plus PAUSE when the optional feature is built). estado_jogo is a direct registered encoding of the state.
- Transitions from RUN:
  - If vitoria_enemy=1 or jogador_vivo=0: go to LOSE. This check has priority over the win check.
  - Else if enemy_vivos is all zero: go to WIN.
  - Else if press: restart pulse; score and nivel are cleared.
- Transitions from WIN:
  - press: go to RUN, restart pulse, nivel+1 (saturates at 15), score is kept.
- Transitions from LOSE:
  - press: go to RUN, restart pulse, score=0, nivel=0.
- Ignore window: for the cycle in which restart is high and the following cycle, enemy_vivos is ignored for scoring and win detection while the field reloads.
- Scoring (RUN only):
  - kill = prev_vivos & ~enemy_vivos, where prev_vivos is registered every cycle.
  - Each killed bit at row r adds (LINHAS - r) points, so the top row is worth the most.
  - Multiple kills in one cycle are summed.
  - score saturates at 2^SCORE_W - 1 and never wraps.
  - Result is visible on the cycle after the kill.
- Fire engine (RUN only):
  - The timer counts to ATRASO-1, then emits a tick.
  - Each tick serves the channel at the channel pointer, then advances the pointer modulo N_TIROS.
  - Start column = LFSR[7:0] mod COLUNAS. The LFSR advances every clk.
  - Scan tests one column per cycle, incrementing with wrap from COLUNAS-1 to 0, for at most COLUNAS cycles.
  - The first column with any live enemy is selected; its highest-index live row is the shooter.
  - On success: the channel's tiro_col and tiro_lin are updated and its tiro_valid pulses for 1 cycle, latency 1..COLUNAS cycles after the tick.
  - If no column is live: no pulse, and the outputs hold their values.
- Leaving RUN mid-scan aborts the scan; no pulse is issued and the timer clears.
- tiro_col and tiro_lin hold their last values between pulses.

Optional Feature:
- Macro: GAME_ENGINE_PAUSE_EN.
- Defined:
  - Adds input btn_P (1 bit, active-low, synchronized and edge-detected like btn_D).
  - In RUN, a press enters PAUSE (estado_jogo=0). A second press returns to RUN.
  - In PAUSE, the timer, scan and scoring are frozen and prev_vivos is not updated. btn_D in PAUSE behaves as in LOSE.
- Undefined: no btn_P port and no PAUSE state; estado_jogo never equals 0.

Decomposition:
- Package game_pkg holds the state encodings (ST_PAUSE=0, ST_RUN=1, ST_WIN=2, ST_LOSE=3), the LFSR taps (x^16+x^14+x^13+x^11+1) and the nivel width.
- One sub-module, lfsr16, with ports clk, reset, seed, q[15:0]. It is shared by future blocks that need pseudo-random values.

Test Plan:
- Reset with LINHAS=5, COLUNAS=11, all alive: score=0, estado_jogo=1, tiro_valid=0, nivel=0.
- Kill bit 0 (row 0) and bit 54 (row 4) in the same cycle: score=6 one cycle later. Force score to 4094 then kill row 0 (+5): score=4095.
- ATRASO=20, only column 3 alive at rows 1 and 2: each tick pulses tiro_valid on channels 0,1,0,1 alternately, every pulse with tiro_col=3 and tiro_lin=2, each pulse within 11 cycles of its tick.
- Clear all bits: estado_jogo=2. Press btn_D: one restart pulse, nivel=1, score unchanged, estado_jogo=1. In the same cycle raise vitoria_enemy with all bits zero: estado_jogo=3.
- Assert reset asynchronously mid-scan: outputs are zero with no clk edge. Hold btn_D low for 100 cycles: exactly one restart pulse.
- With GAME_ENGINE_PAUSE_EN defined: press btn_P, then kill enemies and wait 3 ticks: score, tiro_valid and estado_jogo=0 are unchanged. Press btn_P again: the kills scored in PAUSE do not count; scoring resumes from the new baseline.
